// File: rtl/seq_detector.sv
// Serial bit-pattern detector with a runtime-loadable pattern and length, Mealy or Moore
// output, overlapping or non-overlapping matching, and a saturating match counter.
module seq_detector #(
  parameter int unsigned      PAT_W   = 4,
  parameter int unsigned      CNT_W   = 8,
  parameter logic [PAT_W-1:0] RST_PAT = PAT_W'('b11),
  parameter int unsigned      RST_LEN = 2,
  parameter int unsigned      LEN_W   = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             w,
  input  logic             mealy,
  input  logic             overlap,
  input  logic             pat_ld,
  input  logic [PAT_W-1:0] pat_in,
  input  logic [LEN_W-1:0] len_in,
  input  logic             cnt_clr,
  output logic             z,
  output logic             armed,
  output logic [CNT_W-1:0] match_cnt
);

  localparam logic [LEN_W-1:0] PAT_W_L   = LEN_W'(PAT_W);
  localparam logic [LEN_W-1:0] RST_LEN_C = (RST_LEN == 0)     ? LEN_W'(1) :
                                           (RST_LEN > PAT_W)  ? PAT_W_L   :
                                                                LEN_W'(RST_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  // A length of zero is meaningless and anything above PAT_W cannot be compared.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
    if (l == '0)          return LEN_W'(1);
    else if (l > PAT_W_L) return PAT_W_L;
    else                  return l;
  endfunction

  // Only the newest PAT_W-1 history bits are kept: the oldest bit would never be compared.
  logic [PAT_W-2:0] hist_q, hist_d;
  logic [LEN_W-1:0] fill_q, fill_d;
  logic [PAT_W-1:0] pat_q,  pat_d;
  logic [LEN_W-1:0] len_q,  len_d;
  logic [CNT_W-1:0] cnt_q,  cnt_d;
  logic             zm_q,   zm_d;

  logic [PAT_W-1:0] cand;
  logic [PAT_W-1:0] len_mask;
  logic             armed_c;
  logic             match_c;

  // Candidate window and match term.
  always_comb begin
    cand = {hist_q, w};
    for (int i = 0; i < int'(PAT_W); i++) begin
      len_mask[i] = (LEN_W'(i) < len_q);
    end
    armed_c = (fill_q >= (len_q - LEN_W'(1)));
    match_c = en & ~pat_ld & armed_c & (((cand ^ pat_q) & len_mask) == '0);
  end

  // History, fill level and pattern registers.
  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    pat_d  = pat_q;
    len_d  = len_q;
    if (pat_ld) begin
      pat_d  = pat_in;
      len_d  = clamp_len(len_in);
      hist_d = '0;
      fill_d = '0;
    end else if (en) begin
      hist_d = cand[PAT_W-2:0];
      if (match_c && !overlap) begin
        fill_d = '0;
      end else if (fill_q != PAT_W_L) begin
        fill_d = fill_q + LEN_W'(1);
      end
    end
  end

  // Saturating match counter; any clear beats a same-cycle match.
  always_comb begin
    cnt_d = cnt_q;
    if (pat_ld || cnt_clr) begin
      cnt_d = '0;
    end else if (match_c && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Moore copy tracks the match term every cycle so mode switches are glitch-free.
  always_comb begin
    zm_d = match_c;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_q <= '0;
      fill_q <= '0;
      pat_q  <= RST_PAT;
      len_q  <= RST_LEN_C;
      cnt_q  <= '0;
      zm_q   <= 1'b0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      pat_q  <= pat_d;
      len_q  <= len_d;
      cnt_q  <= cnt_d;
      zm_q   <= zm_d;
    end
  end

  // z is forced low while reset is held, even if the reset length would arm a match.
  assign z         = rst & (mealy ? match_c : zm_q);
  assign armed     = armed_c;
  assign match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_detector.sv
// Directed bench for seq_detector: default "11" behaviour, overlap modes, Moore latency,
// en gaps, length clamping, load priority, counter saturation/clear and async reset.
module tb_seq_detector;

  logic       clk;
  logic       rst;
  logic       en;
  logic       w;
  logic       mealy;
  logic       overlap;
  logic       pat_ld;
  logic [3:0] pat_in;
  logic [2:0] len_in;
  logic       cnt_clr;
  logic       z;
  logic       armed;
  logic [7:0] match_cnt;

  int checks = 0;
  int errors = 0;

  seq_detector dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .w         (w),
    .mealy     (mealy),
    .overlap   (overlap),
    .pat_ld    (pat_ld),
    .pat_in    (pat_in),
    .len_in    (len_in),
    .cnt_clr   (cnt_clr),
    .z         (z),
    .armed     (armed),
    .match_cnt (match_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic drive(input logic e, input logic wb);
    @(negedge clk);
    en = e;
    w  = wb;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [3:0] p, input logic [2:0] l);
    @(negedge clk);
    pat_ld = 1'b1;
    pat_in = p;
    len_in = l;
    en     = 1'b1;
    w      = 1'b1;
    tick();
    pat_ld = 1'b0;
    en     = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    en  = 1'b0;
    rst = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    en  = 1'b1;
    w   = 1'b1;
    #3;
    checks++; if (z !== 1'b0) begin errors++; $display("FAIL reset_z: got %b expected 0", z); end
    checks++; if (match_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", match_cnt); end
    checks++; if (armed !== 1'b0) begin errors++; $display("FAIL reset_armed: got %b expected 0", armed); end
    en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    tick();
    checks++; if (armed !== 1'b0) begin errors++; $display("FAIL reset_armed_post: got %b expected 0", armed); end
  endtask

  task automatic test_default_overlap();
    logic bits [5];
    logic ez   [5];
    bits = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    ez   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    mealy = 1'b1; overlap = 1'b1;
    pulse_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, bits[i]);
      checks++; if (z !== ez[i]) begin errors++; $display("FAIL ovl_z bit%0d: got %b expected %b", i, z, ez[i]); end
      tick();
    end
    checks++; if (match_cnt !== 8'd2) begin errors++; $display("FAIL ovl_cnt: got %0d expected 2", match_cnt); end
  endtask

  task automatic test_non_overlap();
    logic bits [5];
    logic ez   [5];
    bits = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    ez   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    mealy = 1'b1; overlap = 1'b0;
    pulse_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, bits[i]);
      checks++; if (z !== ez[i]) begin errors++; $display("FAIL novl_z bit%0d: got %b expected %b", i, z, ez[i]); end
      tick();
    end
    checks++; if (match_cnt !== 8'd1) begin errors++; $display("FAIL novl_cnt: got %0d expected 1", match_cnt); end
  endtask

  task automatic test_moore_1011();
    logic bits [7];
    logic ez   [7];
    logic ea   [7];
    bits = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    ez   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    ea   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    load(4'b1011, 3'd4);
    mealy = 1'b0; overlap = 1'b1;
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, bits[i]);
      tick();
      checks++; if (z !== ez[i]) begin errors++; $display("FAIL moore_z bit%0d: got %b expected %b", i, z, ez[i]); end
      checks++; if (armed !== ea[i]) begin errors++; $display("FAIL moore_armed bit%0d: got %b expected %b", i, armed, ea[i]); end
    end
    drive(1'b0, 1'b0);
    checks++; if (z !== 1'b1) begin errors++; $display("FAIL moore_hold: got %b expected 1", z); end
    tick();
    checks++; if (z !== 1'b0) begin errors++; $display("FAIL moore_drop: got %b expected 0", z); end
    checks++; if (match_cnt !== 8'd2) begin errors++; $display("FAIL moore_cnt: got %0d expected 2", match_cnt); end
  endtask

  task automatic test_en_gap();
    load(4'b1011, 3'd4);
    mealy = 1'b1; overlap = 1'b1;
    drive(1'b1, 1'b1); tick();
    drive(1'b1, 1'b0); tick();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, i[0]);
      checks++; if (z !== 1'b0) begin errors++; $display("FAIL gap_z cyc%0d: got %b expected 0", i, z); end
      tick();
    end
    checks++; if (armed !== 1'b0) begin errors++; $display("FAIL gap_armed: got %b expected 0", armed); end
    drive(1'b1, 1'b1);
    checks++; if (z !== 1'b0) begin errors++; $display("FAIL gap_z3: got %b expected 0", z); end
    tick();
    drive(1'b1, 1'b1);
    checks++; if (z !== 1'b1) begin errors++; $display("FAIL gap_z4: got %b expected 1", z); end
    tick();
    checks++; if (match_cnt !== 8'd1) begin errors++; $display("FAIL gap_cnt: got %0d expected 1", match_cnt); end
  endtask

  task automatic test_len_clamp();
    mealy = 1'b1; overlap = 1'b1;
    load(4'b0001, 3'd0);
    checks++; if (armed !== 1'b1) begin errors++; $display("FAIL clamp0_armed: got %b expected 1", armed); end
    drive(1'b1, 1'b0);
    checks++; if (z !== 1'b0) begin errors++; $display("FAIL clamp0_z0: got %b expected 0", z); end
    tick();
    drive(1'b1, 1'b1);
    checks++; if (z !== 1'b1) begin errors++; $display("FAIL clamp0_z1: got %b expected 1", z); end
    tick();
    checks++; if (match_cnt !== 8'd1) begin errors++; $display("FAIL clamp0_cnt: got %0d expected 1", match_cnt); end
    load(4'b1011, 3'd7);
    drive(1'b1, 1'b1); tick();
    drive(1'b1, 1'b0); tick();
    checks++; if (armed !== 1'b0) begin errors++; $display("FAIL clamp7_armed2: got %b expected 0", armed); end
    drive(1'b1, 1'b1); tick();
    checks++; if (armed !== 1'b1) begin errors++; $display("FAIL clamp7_armed3: got %b expected 1", armed); end
    drive(1'b1, 1'b1);
    checks++; if (z !== 1'b1) begin errors++; $display("FAIL clamp7_z: got %b expected 1", z); end
    tick();
  endtask

  task automatic test_load_priority();
    mealy = 1'b1; overlap = 1'b1;
    load(4'b0011, 3'd2);
    drive(1'b1, 1'b1); tick();
    @(negedge clk);
    pat_ld = 1'b1; pat_in = 4'b0011; len_in = 3'd2; en = 1'b1; w = 1'b1;
    #1;
    checks++; if (z !== 1'b0) begin errors++; $display("FAIL prio_z: got %b expected 0", z); end
    tick();
    pat_ld = 1'b0; en = 1'b0;
    checks++; if (armed !== 1'b0) begin errors++; $display("FAIL prio_armed: got %b expected 0", armed); end
    checks++; if (match_cnt !== 8'd0) begin errors++; $display("FAIL prio_cnt: got %0d expected 0", match_cnt); end
  endtask

  task automatic test_saturate_clear();
    mealy = 1'b1; overlap = 1'b1;
    load(4'b0011, 3'd2);
    for (int i = 0; i <= 300; i++) begin
      drive(1'b1, 1'b1);
      tick();
      if (i == 254) begin
        checks++; if (match_cnt !== 8'd254) begin errors++; $display("FAIL sat_254: got %0d expected 254", match_cnt); end
      end else if (i == 255 || i == 300) begin
        checks++; if (match_cnt !== 8'd255) begin errors++; $display("FAIL sat_%0d: got %0d expected 255", i, match_cnt); end
      end
    end
    drive(1'b1, 1'b1);
    cnt_clr = 1'b1;
    #1;
    checks++; if (z !== 1'b1) begin errors++; $display("FAIL clr_z: got %b expected 1", z); end
    tick();
    cnt_clr = 1'b0;
    checks++; if (match_cnt !== 8'd0) begin errors++; $display("FAIL clr_cnt: got %0d expected 0", match_cnt); end
    drive(1'b1, 1'b1); tick();
    checks++; if (match_cnt !== 8'd1) begin errors++; $display("FAIL clr_recount: got %0d expected 1", match_cnt); end
  endtask

  task automatic test_async_reset();
    logic bits [6];
    bits = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    mealy = 1'b1; overlap = 1'b1;
    load(4'b1011, 3'd4);
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, bits[i]);
      tick();
    end
    drive(1'b1, 1'b1);
    checks++; if (z !== 1'b1) begin errors++; $display("FAIL arst_pre_z: got %b expected 1", z); end
    checks++; if (match_cnt !== 8'd1) begin errors++; $display("FAIL arst_pre_cnt: got %0d expected 1", match_cnt); end
    rst = 1'b0;
    #1;
    checks++; if (z !== 1'b0) begin errors++; $display("FAIL arst_z: got %b expected 0", z); end
    checks++; if (match_cnt !== 8'd0) begin errors++; $display("FAIL arst_cnt: got %0d expected 0", match_cnt); end
    checks++; if (armed !== 1'b0) begin errors++; $display("FAIL arst_armed: got %b expected 0", armed); end
    en = 1'b0;
    #1;
    rst = 1'b1;
    drive(1'b1, 1'b1);
    checks++; if (z !== 1'b0) begin errors++; $display("FAIL arst_post_z1: got %b expected 0", z); end
    tick();
    checks++; if (armed !== 1'b1) begin errors++; $display("FAIL arst_post_armed: got %b expected 1", armed); end
    drive(1'b1, 1'b1);
    checks++; if (z !== 1'b1) begin errors++; $display("FAIL arst_post_z2: got %b expected 1", z); end
    tick();
    checks++; if (match_cnt !== 8'd1) begin errors++; $display("FAIL arst_post_cnt: got %0d expected 1", match_cnt); end
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; w = 1'b0; mealy = 1'b1; overlap = 1'b1;
    pat_ld = 1'b0; pat_in = 4'b0000; len_in = 3'd0; cnt_clr = 1'b0;
    test_reset();
    test_default_overlap();
    test_non_overlap();
    test_moore_1011();
    test_en_gap();
    test_len_clamp();
    test_load_priority();
    test_saturate_clear();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
